// File: rtl/uart_tx_bus_slave_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: serializer
// state encoding, register offsets from BASE_ADDR and STATUS bit positions.
package uart_tx_bus_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] TXDATA_OFFSET = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_IRQ_EN    = 4;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/uart_tx_bus_slave_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with occupancy count. A push while full
// only lands when a pop happens in the same cycle, so the slot being read
// out is the one that gets reused.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next storage contents, pointers and occupancy for this cycle's push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards all queued bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_bus_slave.sv
// uart_tx_bus_slave: bus-attached UART transmitter. Stores to TXDATA queue
// bytes in a FIFO; an 8N1 serializer drains it onto UART_TX. STATUS gives
// busy/full/empty/overflow and the FIFO count.
// Optional feature macro UART_TX_IRQ_EN adds tx_irq and the STATUS irq_enable bit.
module uart_tx_bus_slave
    import uart_tx_bus_slave_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 10416,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0030
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        UART_TX
`ifdef UART_TX_IRQ_EN
    ,
    output logic        tx_irq
`endif
);

    localparam int          CW          = $clog2(CLKS_PER_BIT);
    localparam int          CNTW        = $clog2(FIFO_DEPTH) + 1;
    localparam int          CNT_FIELD_W = (CNTW > 8) ? 8 : CNTW;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFFSET;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFFSET;

    tx_state_e      state_q, state_d;
    logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           overflow_q, overflow_d;

    logic           wr_txdata;
    logic           wr_status;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CNTW-1:0] fifo_count;
    logic [2:0]     next_bit;
    logic           phase_end;
    logic [31:0]    status_word;
    logic           unused_wdata;

    assign wr_txdata    = wr && (addr == TXDATA_ADDR);
    assign wr_status    = wr && (addr == STATUS_ADDR);
    assign next_bit     = bit_idx_q + 3'd1;
    assign phase_end    = (clk_cnt_q == CNT_MAX);
    assign UART_TX      = tx_q;
    assign unused_wdata = ^wdata[31:8];

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .din   (wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serializer next state: the line level is computed one cycle ahead so UART_TX comes straight from a flop
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (phase_end) begin
                    clk_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (phase_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = next_bit;
                        tx_d      = shift_q[next_bit];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (phase_end) begin
                    clk_cnt_d = '0;
                    tx_d      = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serializer registers; reset forces the line high and aborts any frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Sticky overflow: a dropped byte wins over a same-cycle software clear
    always_comb begin
        overflow_d = overflow_q;
        if (wr_status && wdata[STAT_OVERFLOW]) begin
            overflow_d = 1'b0;
        end
        if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic tx_irq_q, tx_irq_d;

    assign tx_irq = tx_irq_q;

    // Interrupt enable is rewritten by every STATUS store; the request means "all data sent"
    always_comb begin
        irq_en_d = wr_status ? wdata[STAT_IRQ_EN] : irq_en_q;
        tx_irq_d = irq_en_q && fifo_empty && (state_q == ST_IDLE);
    end

    // Interrupt enable and registered request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            tx_irq_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            tx_irq_q <= tx_irq_d;
        end
    end
`endif

    // STATUS assembly and read mux; TXDATA and unmapped addresses read as zero
    always_comb begin
        status_word                                = '0;
        status_word[STAT_BUSY]                     = (state_q != ST_IDLE);
        status_word[STAT_FULL]                     = fifo_full;
        status_word[STAT_EMPTY]                    = fifo_empty;
        status_word[STAT_OVERFLOW]                 = overflow_q;
`ifdef UART_TX_IRQ_EN
        status_word[STAT_IRQ_EN]                   = irq_en_q;
`endif
        status_word[STAT_COUNT_LSB +: CNT_FIELD_W] = fifo_count[CNT_FIELD_W-1:0];
        rdata = '0;
        if (rd && (addr == STATUS_ADDR)) begin
            rdata = status_word;
        end
    end

endmodule

// File: tb/tb_uart_tx_bus_slave.sv
// Self-checking bench for uart_tx_bus_slave with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A line monitor decodes frames and checks them against a scoreboard queue
// filled when bytes that must be transmitted are written.
module tb_uart_tx_bus_slave;

    localparam int          CPB  = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE = 32'h4000_0030;
    localparam logic [31:0] TXA  = BASE;
    localparam logic [31:0] STA  = BASE + 32'h4;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        UART_TX;
`ifdef UART_TX_IRQ_EN
    logic        tx_irq;
`endif

    int          testsRun;
    int          testsFailed;
    int          cyc;
    int          framesSeen;
    int          frameStarts[$];
    logic [7:0]  expQ[$];
    logic        monEn;

    uart_tx_bus_slave #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .UART_TX (UART_TX)
`ifdef UART_TX_IRQ_EN
        ,
        .tx_irq  (tx_irq)
`endif
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        testsRun++;
        if (got !== expv) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    // One bus write; bytes that must appear on the line go into the scoreboard
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic expectTx);
        @(negedge clk);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        if (expectTx) expQ.push_back(d[7:0]);
    endtask

    // Combinational bus read, done mid-cycle
    task automatic readReg(input logic [31:0] a, input logic rdStrobe, output logic [31:0] v);
        rd   = rdStrobe;
        addr = a;
        #1;
        v    = rdata;
        rd   = 1'b0;
        addr = '0;
    endtask

    // Wait for a frame total with a cycle budget; expiry shows up as a failed compare
    task automatic waitFrames(input int target, input int budget);
        for (int i = 0; i < budget && framesSeen < target; i++) @(posedge clk);
        #1;
        checkOutput("frames_seen", 32'(framesSeen), 32'(target));
    endtask

    // Line monitor: decode 8N1 frames at mid-bit and score them
    always begin : monitor
        logic [7:0] got;
        logic       stopBit;
        logic       aborted;
        int         startCyc;
        @(negedge clk);
        if (monEn && !reset && UART_TX === 1'b0) begin
            startCyc = cyc;
            got      = '0;
            stopBit  = 1'b0;
            aborted  = 1'b0;
            for (int c = 1; c < 10 * CPB; c++) begin
                @(negedge clk);
                if (!monEn || reset) begin
                    aborted = 1'b1;
                    break;
                end
                if (c >= CPB + 1 && c < 9 * CPB && ((c - CPB - 1) % CPB) == 0)
                    got = {UART_TX, got[7:1]};
                if (c == 9 * CPB + 1) stopBit = UART_TX;
            end
            if (!aborted) begin
                frameStarts.push_back(startCyc);
                framesSeen++;
                checkOutput("frame_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) checkOutput("frame_data", 32'(got), 32'(expQ.pop_front()));
                checkOutput("stop_bit", 32'(stopBit), 32'd1);
            end
        end
    end

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        logic [31:0] v;
        int          base;
        int          seen;
        testsRun    = 0;
        testsFailed = 0;
        cyc         = 0;
        framesSeen  = 0;
        monEn       = 1'b1;
        reset       = 1'b1;
        rd          = 1'b0;
        wr          = 1'b0;
        addr        = '0;
        wdata       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("reset_tx", 32'(UART_TX), 32'd1);
        readReg(STA, 1'b1, v);
        checkOutput("reset_status", v, 32'h0000_0004);
`ifdef UART_TX_IRQ_EN
        checkOutput("reset_irq", 32'(tx_irq), 32'd0);
`endif

        $display("[TB] single frame 0xA5");
        applyStimulus(TXA, 32'hA5, 1'b1);
        checkOutput("tx_idle_at_write", 32'(UART_TX), 32'd1);
        readReg(STA, 1'b1, v);
        checkOutput("status_after_push", v, 32'h0000_0100);
        @(posedge clk);
        #1;
        checkOutput("tx_start_low", 32'(UART_TX), 32'd0);
        readReg(STA, 1'b1, v);
        checkOutput("status_busy", v, 32'h0000_0005);
        repeat (39) @(posedge clk);
        #1;
        readReg(STA, 1'b1, v);
        checkOutput("status_busy_last_cycle", v, 32'h0000_0005);
        checkOutput("tx_stop_high", 32'(UART_TX), 32'd1);
        @(posedge clk);
        #1;
        readReg(STA, 1'b1, v);
        checkOutput("status_idle_after_frame", v, 32'h0000_0004);
        checkOutput("frames_after_a5", 32'(framesSeen), 32'd1);

        $display("[TB] back-to-back frames");
        base = frameStarts.size();
        applyStimulus(TXA, 32'h11, 1'b1);
        applyStimulus(TXA, 32'h22, 1'b1);
        applyStimulus(TXA, 32'h33, 1'b1);
        readReg(STA, 1'b1, v);
        checkOutput("count_after_three", v, 32'h0000_0201);
        waitFrames(4, 3 * 41 + 20);
        if (frameStarts.size() >= base + 3) begin
            checkOutput("gap_1_2", 32'(frameStarts[base+1] - frameStarts[base]), 32'd41);
            checkOutput("gap_2_3", 32'(frameStarts[base+2] - frameStarts[base+1]), 32'd41);
        end

        $display("[TB] overflow");
        repeat (3) @(posedge clk);
        applyStimulus(TXA, 32'h3C, 1'b1);
        for (int i = 1; i <= 8; i++) applyStimulus(TXA, 32'(8'hC0 + i), 1'b1);
        applyStimulus(TXA, 32'hEE, 1'b0);
        readReg(STA, 1'b1, v);
        checkOutput("status_full_overflow", v, 32'h0000_080B);
        applyStimulus(STA, 32'h8, 1'b0);
        readReg(STA, 1'b1, v);
        checkOutput("status_overflow_cleared", v, 32'h0000_0803);
        waitFrames(13, 9 * 41 + 40);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        seen = framesSeen;
        repeat (60) @(posedge clk);
        #1;
        checkOutput("dropped_byte_not_sent", 32'(framesSeen), 32'(seen));
        readReg(STA, 1'b1, v);
        checkOutput("status_idle_after_burst", v, 32'h0000_0004);

        $display("[TB] read decode");
        readReg(BASE + 32'h8, 1'b1, v);
        checkOutput("rdata_unmapped", v, 32'h0);
        readReg(TXA, 1'b1, v);
        checkOutput("rdata_txdata", v, 32'h0);
        readReg(STA, 1'b0, v);
        checkOutput("rdata_no_rd", v, 32'h0);

`ifdef UART_TX_IRQ_EN
        $display("[TB] interrupt");
        applyStimulus(STA, 32'h10, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("irq_idle_enabled", 32'(tx_irq), 32'd1);
        readReg(STA, 1'b1, v);
        checkOutput("status_irq_en", v, 32'h0000_0014);
        applyStimulus(TXA, 32'h5A, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("irq_low_in_frame", 32'(tx_irq), 32'd0);
        repeat (39) @(posedge clk);
        #1;
        checkOutput("irq_low_first_idle", 32'(tx_irq), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("irq_high_after_idle", 32'(tx_irq), 32'd1);
        applyStimulus(STA, 32'h0, 1'b0);
`else
        $display("[TB] irq bit absent");
        applyStimulus(STA, 32'h10, 1'b0);
        readReg(STA, 1'b1, v);
        checkOutput("status_bit4_ignored", v, 32'h0000_0004);
`endif

        $display("[TB] reset mid-frame");
        repeat (3) @(posedge clk);
        applyStimulus(TXA, 32'h00, 1'b0);
        applyStimulus(TXA, 32'h01, 1'b0);
        applyStimulus(TXA, 32'h02, 1'b0);
        applyStimulus(TXA, 32'h03, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        readReg(STA, 1'b1, v);
        checkOutput("status_three_queued", v, 32'h0000_0301);
        checkOutput("tx_low_mid_frame", 32'(UART_TX), 32'd0);
        seen  = framesSeen;
        monEn = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("tx_high_on_reset", 32'(UART_TX), 32'd1);
        readReg(STA, 1'b1, v);
        checkOutput("status_in_reset", v, 32'h0000_0004);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        monEn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("no_frames_after_reset", 32'(framesSeen), 32'(seen));
        checkOutput("tx_idle_after_reset", 32'(UART_TX), 32'd1);
        readReg(STA, 1'b1, v);
        checkOutput("status_after_reset", v, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_tx_bus_slave.md
# uart_tx_bus_slave

Memory-mapped UART transmit responder on the CPU data bus. Sits beside the peripheral block and answers the same rd/wr/addr/wdata/rdata bus the CPU drives. CPU stores push bytes into an internal FIFO; a serializer drains the FIFO onto UART_TX as 8N1 frames. Status is readable so software can poll for room instead of spinning on a single-byte transmitter.

## Interface
- CLKS_PER_BIT, default 10416: clk cycles per serial bit; must be ≥2.
- FIFO_DEPTH, default 8: TX FIFO entries; power of two, 2..256.
- BASE_ADDR, default 32'h40000030: word-aligned base address; TXDATA at BASE_ADDR+0, STATUS at BASE_ADDR+4.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd  input  1  bus read strobe.
- wr  input  1  bus write strobe, sampled on rising clk.
- addr  input  32  byte address; only exact matches to the two registers are decoded.
- wdata  input  32  write data.
- rdata  output  32  read data, combinational.
- UART_TX  output  1  serial line, idle high.

## Operation
- TXDATA write (wr, addr==BASE_ADDR): push wdata[7:0]. FIFO full → byte dropped, sticky overflow bit set. TXDATA reads return 0.
- STATUS read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow, bits[15:8] FIFO count, other bits 0.
- STATUS write: wdata[3]=1 clears overflow; other bits ignored (see Configuration).
- rdata = selected register when rd && address matches, else 32'h0.
- Serializer FSM IDLE→START→DATA→STOP→IDLE:
  - IDLE: UART_TX=1. FIFO non-empty → pop head into shift register, clear counters, go START.
  - START: UART_TX=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; 3-bit bit index.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles, then IDLE.
- Cycle counter counts 0..CLKS_PER_BIT-1, wraps at phase end; width $clog2(CLKS_PER_BIT).
- FIFO count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Push and pop same cycle while full: both take effect, count unchanged, no overflow. Same cycle while empty cannot occur (pop needs registered non-empty).
- UART_TX is registered; no glitches.

## Timing
- Reset values: UART_TX=1, FSM IDLE, FIFO empty (count 0), overflow 0, rdata 0 when not addressed.
- Reset asserted mid-frame: line forced high immediately, FIFO contents discarded, frame aborted.
- Write at edge k into empty FIFO while IDLE: pop at edge k+1; UART_TX low from edge k+1.
- Frame = 10·CLKS_PER_BIT cycles; back-to-back frames separated by exactly one IDLE cycle (period 10·CLKS_PER_BIT+1).
- STATUS reflects state after the most recent edge; a push at edge k is visible in count after edge k.

## Configuration
- UART_TX_IRQ_EN defined: adds output tx_irq (1 bit, reset 0) and STATUS bit4 irq_enable (R/W via wdata[4], reset 0). tx_irq = irq_enable && FIFO empty && FSM IDLE, registered.
- Not defined: no tx_irq port; STATUS bit4 reads 0, writes ignored.

## Structure
- Shared package: FSM state enum (IDLE, START, DATA, STOP), register offsets (TXDATA 0, STATUS 4), STATUS bit positions.
- One sub-module: byte_fifo (synchronous FIFO, parameter DEPTH, push/pop/full/empty/count, async active-high reset).
- Serializer and bus decode stay in the top.

## Test plan
- CLKS_PER_BIT=4, write 0xA5 to TXDATA → UART_TX low at next cycle, then 1,0,1,0,0,1,0,1 (4 cycles each), high stop; 40 cycles total; STATUS busy=1 during frame, then 0.
- Write 0x11,0x22,0x33 in consecutive cycles → three frames, each 41 cycles apart start-to-start; count reads 2 right after the third write.
- FIFO_DEPTH=8, nine writes while line busy → full=1, ninth byte never transmitted, overflow=1; STATUS write wdata=0x8 → overflow=0.
- Assert reset 13 cycles into a frame with 3 bytes queued → UART_TX=1 same cycle, STATUS reads count 0, empty=1; no further frames.
- Read unmapped BASE_ADDR+8 and TXDATA with rd=1 → rdata=0; rd=0 on STATUS → rdata=0.
- With UART_TX_IRQ_EN: write STATUS 0x10, send one byte → tx_irq 0 during frame, 1 one cycle after return to IDLE with FIFO empty.
